// File: rtl/hs_npu_memory_ordering_ctrl_pkg.sv
// Shared types for the NPU memory ordering controller:
// FSM states, request kinds, latched job bundle and helpers.
package hs_npu_pkg;

    typedef logic [31:0] uword;

    typedef enum logic [2:0] {
        MO_IDLE,
        MO_LOAD_W,
        MO_LOAD_I,
        MO_LOAD_B,
        MO_COMPUTE,
        MO_STORE,
        MO_DONE
    } mo_state_e;

    typedef enum logic [1:0] {
        KIND_WEIGHT = 2'd0,
        KIND_INPUT  = 2'd1,
        KIND_BIAS   = 2'd2,
        KIND_OUTPUT = 2'd3
    } mem_kind_e;

    typedef struct packed {
        uword w_cnt;
        uword i_cnt;
        uword b_cnt;
        uword o_cnt;
        uword base;
        uword result;
        logic reuse_in;
        logic reuse_wt;
        logic save;
        logic bias;
    } mo_job_t;

    // Low word of the full-width product; the truncating multiply is identical.
    function automatic uword mul_lo(uword a, uword b);
        return a * b;
    endfunction

    function automatic mo_state_e mo_next(mo_state_e s, mo_job_t j);
        logic      skw;
        logic      ski;
        logic      skb;
        logic      sks;
        mo_state_e n;
        skw = j.reuse_wt || (j.w_cnt == '0);
        ski = j.reuse_in || (j.i_cnt == '0);
        skb = !j.bias;
        sks = !j.save || (j.o_cnt == '0);
        n   = MO_IDLE;
        unique case (s)
            MO_IDLE:
                n = !skw ? MO_LOAD_W :
                    !ski ? MO_LOAD_I :
                    !skb ? MO_LOAD_B : MO_COMPUTE;
            MO_LOAD_W:
                n = !ski ? MO_LOAD_I :
                    !skb ? MO_LOAD_B : MO_COMPUTE;
            MO_LOAD_I:
                n = !skb ? MO_LOAD_B : MO_COMPUTE;
            MO_LOAD_B:  n = MO_COMPUTE;
            MO_COMPUTE: n = !sks ? MO_STORE : MO_DONE;
            MO_STORE:   n = MO_DONE;
            default:    n = MO_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hs_npu_memory_ordering_ctrl_if.sv
// Memory request/response channel between the ordering
// controller (master) and the memory system (slave).
interface hs_npu_memory_ordering_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [DATA_W-1:0] mem_req_addr_o;
    logic              mem_req_write_o;
    logic [1:0]        mem_req_kind_o;
    logic              mem_rsp_valid_i;

    modport master (
        output mem_req_valid_o,
        output mem_req_addr_o,
        output mem_req_write_o,
        output mem_req_kind_o,
        input  mem_req_ready_i,
        input  mem_rsp_valid_i
    );

    modport slave (
        input  mem_req_valid_o,
        input  mem_req_addr_o,
        input  mem_req_write_o,
        input  mem_req_kind_o,
        output mem_req_ready_i,
        output mem_rsp_valid_i
    );
endinterface

// File: rtl/hs_npu_mo_stream.sv
// Single-phase request streamer: issues N word requests at
// consecutive addresses under an outstanding-request limit.
module hs_npu_mo_stream
    import hs_npu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int OUTST_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [DATA_W-1:0]             i_base,
    input  logic [DATA_W-1:0]             i_count,
    input  mem_kind_e                     i_kind,
    hs_npu_memory_ordering_ctrl_if.master mem,
    output logic                          o_phase_done
);
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    logic               r_active;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_count;
    logic [DATA_W-1:0]  r_issued;
    logic [DATA_W-1:0]  r_resp;
    logic [OUTST_W-1:0] r_outst;
    mem_kind_e          r_kind;

    logic w_issue;
    logic w_rsp;

    assign mem.mem_req_valid_o = r_active
                              && (r_issued != r_count)
                              && (r_outst != OUTST_MAX);
    assign mem.mem_req_addr_o  = r_addr;
    assign mem.mem_req_kind_o  = r_kind;
    assign mem.mem_req_write_o = r_active && (r_kind == KIND_OUTPUT);

    assign w_issue = mem.mem_req_valid_o && mem.mem_req_ready_i;
    // Stray responses with nothing in flight are dropped here.
    assign w_rsp   = mem.mem_rsp_valid_i && (r_outst != '0);

    assign o_phase_done = r_active
        && ((r_count == '0)
         || (w_rsp && ((r_resp + DATA_W'(1)) == r_count)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_addr   <= '0;
            r_count  <= '0;
            r_issued <= '0;
            r_resp   <= '0;
            r_outst  <= '0;
            r_kind   <= KIND_WEIGHT;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_addr   <= i_base;
            r_count  <= i_count;
            r_issued <= '0;
            r_resp   <= '0;
            r_outst  <= '0;
            r_kind   <= i_kind;
        end else begin
            if (o_phase_done) begin
                r_active <= 1'b0;
            end
            if (w_issue) begin
                r_issued <= r_issued + DATA_W'(1);
                r_addr   <= r_addr + DATA_W'(WORD_BYTES);
            end
            if (w_rsp) begin
                r_resp <= r_resp + DATA_W'(1);
            end
            if (w_issue && !w_rsp) begin
                r_outst <= r_outst + OUTST_W'(1);
            end else if (!w_issue && w_rsp) begin
                r_outst <= r_outst - OUTST_W'(1);
            end
        end
    end
endmodule

// File: rtl/hs_npu_memory_ordering_ctrl.sv
// Layer job sequencer: accepts a job, then runs weight, input,
// bias, compute and store phases and pulses finished.
module hs_npu_memory_ordering_ctrl
    import hs_npu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int OUTST_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          finished_o,
    input  logic [DATA_W-1:0]             num_input_rows_i,
    input  logic [DATA_W-1:0]             num_input_columns_i,
    input  logic [DATA_W-1:0]             num_weight_rows_i,
    input  logic [DATA_W-1:0]             num_weight_columns_i,
    input  logic                          reuse_inputs_i,
    input  logic                          reuse_weights_i,
    input  logic                          save_outputs_i,
    input  logic                          use_bias_i,
    input  logic [DATA_W-1:0]             base_address_i,
    input  logic [DATA_W-1:0]             result_address_i,
    hs_npu_memory_ordering_ctrl_if.master mem,
    output logic                          compute_start_o,
    input  logic                          compute_done_i
);
    localparam logic [DATA_W-1:0] STRIDE = DATA_W'(WORD_BYTES);

    mo_state_e r_state;
    mo_job_t   r_job;
    logic      r_started;

    mo_state_e         w_next;
    mo_job_t           w_new;
    mo_job_t           w_jsel;
    logic              w_start;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_count;
    mem_kind_e         w_kind;
    logic              w_done;

    assign ready_o         = (r_state == MO_IDLE);
    assign finished_o      = (r_state == MO_DONE);
    assign compute_start_o = (r_state == MO_COMPUTE) && !r_started;

    always_comb begin
        w_new.w_cnt    = mul_lo(num_weight_rows_i, num_weight_columns_i);
        w_new.i_cnt    = mul_lo(num_input_rows_i, num_input_columns_i);
        w_new.b_cnt    = num_weight_columns_i;
        w_new.o_cnt    = mul_lo(num_input_rows_i, num_weight_columns_i);
        w_new.base     = base_address_i;
        w_new.result   = result_address_i;
        w_new.reuse_in = reuse_inputs_i;
        w_new.reuse_wt = reuse_weights_i;
        w_new.save     = save_outputs_i;
        w_new.bias     = use_bias_i;
    end

    // The first phase is launched on the accept edge, before r_job is loaded.
    assign w_jsel = (r_state == MO_IDLE) ? w_new : r_job;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_base  = '0;
        w_count = '0;
        w_kind  = KIND_WEIGHT;
        unique case (r_state)
            MO_IDLE:
                if (valid_i) w_next = mo_next(MO_IDLE, w_new);
            MO_LOAD_W, MO_LOAD_I, MO_LOAD_B, MO_STORE:
                if (w_done) w_next = mo_next(r_state, r_job);
            MO_COMPUTE:
                if (compute_done_i) w_next = mo_next(MO_COMPUTE, r_job);
            MO_DONE:
                w_next = MO_IDLE;
            default:
                w_next = MO_IDLE;
        endcase
        if (w_next != r_state) begin
            unique case (w_next)
                MO_LOAD_W: begin
                    w_start = 1'b1;
                    w_base  = w_jsel.base;
                    w_count = w_jsel.w_cnt;
                    w_kind  = KIND_WEIGHT;
                end
                MO_LOAD_I: begin
                    w_start = 1'b1;
                    w_base  = w_jsel.base + w_jsel.w_cnt * STRIDE;
                    w_count = w_jsel.i_cnt;
                    w_kind  = KIND_INPUT;
                end
                MO_LOAD_B: begin
                    w_start = 1'b1;
                    w_base  = w_jsel.base
                            + (w_jsel.w_cnt + w_jsel.i_cnt) * STRIDE;
                    w_count = w_jsel.b_cnt;
                    w_kind  = KIND_BIAS;
                end
                MO_STORE: begin
                    w_start = 1'b1;
                    w_base  = w_jsel.result;
                    w_count = w_jsel.o_cnt;
                    w_kind  = KIND_OUTPUT;
                end
                default: w_start = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= MO_IDLE;
            r_job     <= '0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_started <= (r_state == MO_COMPUTE) && (w_next == MO_COMPUTE);
            if ((r_state == MO_IDLE) && valid_i) begin
                r_job <= w_new;
            end
        end
    end

    hs_npu_mo_stream #(
        .DATA_W     (DATA_W),
        .WORD_BYTES (WORD_BYTES),
        .OUTST_W    (OUTST_W)
    ) u_stream (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_base       (w_base),
        .i_count      (w_count),
        .i_kind       (w_kind),
        .mem          (mem),
        .o_phase_done (w_done)
    );
endmodule

// File: tb/tb_hs_npu_memory_ordering_ctrl.sv
// Bench for the memory ordering controller: memory/compute responders
// plus a request-list reference model built from the job parameters.
module tb_hs_npu_memory_ordering_ctrl;

    typedef struct {
        logic [31:0] ir, ic, wr, wc;
        logic        rw, ri, sv, ub;
        logic [31:0] base, res;
    } job_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic        write;
    } req_t;

    logic        clk, rst, valid_i, ready_o, finished_o;
    logic [31:0] nir, nic, nwr, nwc, base_a, res_a;
    logic        reuse_in, reuse_wt, save_o, use_b;
    logic        cstart, cdone;

    hs_npu_memory_ordering_ctrl_if #(.DATA_W(32)) mem_if ();

    hs_npu_memory_ordering_ctrl #(
        .DATA_W(32), .WORD_BYTES(4), .OUTST_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .finished_o(finished_o),
        .num_input_rows_i(nir), .num_input_columns_i(nic),
        .num_weight_rows_i(nwr), .num_weight_columns_i(nwc),
        .reuse_inputs_i(reuse_in), .reuse_weights_i(reuse_wt),
        .save_outputs_i(save_o), .use_bias_i(use_b),
        .base_address_i(base_a), .result_address_i(res_a),
        .mem(mem_if),
        .compute_start_o(cstart), .compute_done_i(cdone)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rdy_mode = 0;
    int lat = 2;
    int rsp_hold = 0;
    int rsp_grant = 0;
    int cd_tie = 1;
    int cd_delay = 0;
    int cd_due = -1;
    int cd_cyc = -1;
    int fin_count = 0;
    int fin_cyc = -1;
    int cs_count = 0;
    int acc_cyc = -1;
    int rsp_q[$];
    req_t log_q[$];
    req_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [1:0]  prev_kind;
    logic        prev_write;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory and compute responders; sample 1 time unit before each posedge.
    initial begin
        mem_if.mem_req_ready_i = 1'b0;
        mem_if.mem_rsp_valid_i = 1'b0;
        cdone = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (rdy_mode)
                1: mem_if.mem_req_ready_i = (cyc % 2) == 1;
                2: mem_if.mem_req_ready_i = ($urandom % 2) == 1;
                default: mem_if.mem_req_ready_i = 1'b1;
            endcase
            mem_if.mem_rsp_valid_i = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0] <= cyc
                && (rsp_hold == 0 || rsp_grant > 0)) begin
                mem_if.mem_rsp_valid_i = 1'b1;
                void'(rsp_q.pop_front());
                if (rsp_hold != 0) rsp_grant--;
            end
            cdone = (cd_tie != 0) || (cd_due == cyc);
            if (cd_due == cyc) cd_cyc = cyc;
            #4;
            if (rst) begin
                rsp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", mem_if.mem_req_valid_o, 1);
                    chk("hold_addr", mem_if.mem_req_addr_o, prev_addr);
                    chk("hold_kind", mem_if.mem_req_kind_o, prev_kind);
                    chk("hold_write", mem_if.mem_req_write_o, prev_write);
                end
                if (mem_if.mem_req_valid_o && mem_if.mem_req_ready_i) begin
                    log_q.push_back('{mem_if.mem_req_kind_o,
                                      mem_if.mem_req_addr_o,
                                      mem_if.mem_req_write_o});
                    rsp_q.push_back(cyc + lat);
                end
                prev_stall = mem_if.mem_req_valid_o && !mem_if.mem_req_ready_i;
                prev_addr  = mem_if.mem_req_addr_o;
                prev_kind  = mem_if.mem_req_kind_o;
                prev_write = mem_if.mem_req_write_o;
                if (cstart) begin
                    cs_count++;
                    if (cd_delay > 0) cd_due = cyc + cd_delay;
                end
                if (finished_o) begin
                    fin_count++;
                    fin_cyc = cyc;
                end
            end
        end
    end

    // Reference: the ordered list of requests a job must produce.
    task automatic build_exp(job_t j);
        logic [31:0] w, i, b, o, ib, bb;
        exp_q.delete();
        w  = j.wr * j.wc;
        i  = j.ir * j.ic;
        b  = j.wc;
        o  = j.ir * j.wc;
        ib = j.base + w * 4;
        bb = j.base + (w + i) * 4;
        if (!j.rw)
            for (int k = 0; k < int'(w); k++)
                exp_q.push_back('{2'd0, j.base + 32'(k) * 4, 1'b0});
        if (!j.ri)
            for (int k = 0; k < int'(i); k++)
                exp_q.push_back('{2'd1, ib + 32'(k) * 4, 1'b0});
        if (j.ub)
            for (int k = 0; k < int'(b); k++)
                exp_q.push_back('{2'd2, bb + 32'(k) * 4, 1'b0});
        if (j.sv)
            for (int k = 0; k < int'(o); k++)
                exp_q.push_back('{2'd3, j.res + 32'(k) * 4, 1'b1});
    endtask

    task automatic cmp_log(string tag);
        chk({tag, "_nreq"}, log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            chk({tag, "_kind"}, log_q[k].kind, exp_q[k].kind);
            chk({tag, "_addr"}, log_q[k].addr, exp_q[k].addr);
            chk({tag, "_wr"}, log_q[k].write, exp_q[k].write);
        end
    endtask

    task automatic start_job(job_t j);
        log_q.delete();
        build_exp(j);
        @(negedge clk);
        nir = j.ir; nic = j.ic; nwr = j.wr; nwc = j.wc;
        reuse_wt = j.rw; reuse_in = j.ri; save_o = j.sv; use_b = j.ub;
        base_a = j.base; res_a = j.res;
        valid_i = 1'b1;
        #4;
        chk("ready_idle", ready_o, 1);
        acc_cyc = cyc;
        @(negedge clk);
        valid_i = 1'b0;
        #4;
        chk("ready_drop", ready_o, 0);
    endtask

    task automatic wait_fin(int n0, string tag);
        int k = 0;
        while (fin_count == n0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_fin"}, fin_count != n0, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_job(job_t j, string tag);
        int f0, c0;
        f0 = fin_count;
        c0 = cs_count;
        start_job(j);
        wait_fin(f0, tag);
        chk({tag, "_one_fin"}, fin_count - f0, 1);
        chk({tag, "_one_cs"}, cs_count - c0, 1);
        cmp_log(tag);
    endtask

    initial begin
        job_t j, jf;
        int f0, k;
        rst = 1'b1; valid_i = 1'b0;
        nir = '0; nic = '0; nwr = '0; nwc = '0;
        reuse_in = 0; reuse_wt = 0; save_o = 0; use_b = 0;
        base_a = '0; res_a = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_ready", ready_o, 1);
        chk("rst_fin", finished_o, 0);
        chk("rst_valid", mem_if.mem_req_valid_o, 0);
        chk("rst_write", mem_if.mem_req_write_o, 0);
        chk("rst_addr", mem_if.mem_req_addr_o, 0);
        chk("rst_kind", mem_if.mem_req_kind_o, 0);
        chk("rst_cstart", cstart, 0);
        @(negedge clk);
        rst = 1'b0;

        jf = '{32'd2, 32'd3, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1,
               32'h1000, 32'h8000};
        run_job(jf, "full");

        cd_tie = 0; cd_delay = 5;
        j = '{32'd2, 32'd3, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0,
              32'h2000, 32'h9000};
        run_job(j, "reuse");
        chk("reuse_fin_after_done", fin_cyc - cd_cyc, 1);

        cd_tie = 1; cd_delay = 0;
        run_job(j, "min");
        // accept cycle, COMPUTE cycle, then DONE: three cycles inclusive
        chk("min_latency", fin_cyc - acc_cyc, 2);

        rdy_mode = 1;
        j = '{32'd1, 32'd1, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0,
              32'h3000, 32'h0};
        run_job(j, "bp");
        rdy_mode = 0;

        rsp_hold = 1; rsp_grant = 0;
        j = '{32'd1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0,
              32'h4000, 32'h0};
        f0 = fin_count;
        start_job(j);
        repeat (10) @(negedge clk);
        #4;
        chk("outst_nreq3", log_q.size(), 3);
        chk("outst_stall", mem_if.mem_req_valid_o, 0);
        rsp_grant = 1;
        repeat (10) @(negedge clk);
        #4;
        chk("outst_nreq4", log_q.size(), 4);
        chk("outst_stall2", mem_if.mem_req_valid_o, 0);
        rsp_hold = 0;
        wait_fin(f0, "outst");
        cmp_log("outst");

        f0 = fin_count;
        start_job(jf);
        k = 0;
        while (k < 500 && !(log_q.size() > 0
               && log_q[log_q.size()-1].kind == 2'd1)) begin
            @(posedge clk);
            k++;
        end
        chk("busy_in_load_i", k < 500, 1);
        @(negedge clk);
        nwr = 32'd7; base_a = 32'h5555_0000;
        valid_i = 1'b1;
        #4;
        chk("busy_ready", ready_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        wait_fin(f0, "busy");
        chk("busy_one_fin", fin_count - f0, 1);
        build_exp(jf);
        cmp_log("busy");

        f0 = fin_count;
        start_job(jf);
        k = 0;
        while (k < 500 && !(log_q.size() > 0
               && log_q[log_q.size()-1].kind == 2'd3)) begin
            @(posedge clk);
            k++;
        end
        chk("rst_in_store", k < 500, 1);
        @(negedge clk);
        rst = 1'b1;
        #4;
        chk("mrst_ready", ready_o, 1);
        chk("mrst_valid", mem_if.mem_req_valid_o, 0);
        chk("mrst_fin", finished_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_no_fin", fin_count - f0, 0);
        run_job(jf, "after_rst");

        j = '{32'd1, 32'd1, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0,
              32'hFFFF_FFF8, 32'h0};
        run_job(j, "wrap");
        if (log_q.size() == 4) begin
            chk("wrap_a0", log_q[0].addr, 32'hFFFF_FFF8);
            chk("wrap_a1", log_q[1].addr, 32'hFFFF_FFFC);
            chk("wrap_a2", log_q[2].addr, 32'h0);
            chk("wrap_a3", log_q[3].addr, 32'h4);
        end

        for (int n = 0; n < 8; n++) begin
            rdy_mode = 2;
            lat = $urandom_range(1, 4);
            cd_delay = $urandom_range(0, 3);
            cd_tie = (cd_delay == 0) ? 1 : 0;
            j.ir = $urandom_range(0, 3);
            j.ic = $urandom_range(0, 3);
            j.wr = $urandom_range(0, 3);
            j.wc = $urandom_range(0, 3);
            j.rw = $urandom_range(0, 1);
            j.ri = $urandom_range(0, 1);
            j.sv = $urandom_range(0, 1);
            j.ub = $urandom_range(0, 1);
            j.base = $urandom & 32'hFFFF_FFFC;
            j.res = $urandom & 32'hFFFF_FFFC;
            run_job(j, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
